// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        REFILL = 2'd3
    } state_e;

    function automatic int tag_w(input int addr_w, input int blkidx_bit, input int offset_bit);
        return addr_w - blkidx_bit - offset_bit;
    endfunction

    // Helpers work on a 64-bit view so one body serves any address width.
    function automatic logic [63:0] addr_tag(input logic [63:0] a, input int blkidx_bit,
                                             input int offset_bit);
        return a >> (blkidx_bit + offset_bit);
    endfunction

    function automatic logic [63:0] addr_idx(input logic [63:0] a, input int blkidx_bit,
                                             input int offset_bit);
        return (a >> offset_bit) & ((64'd1 << blkidx_bit) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_word(input logic [63:0] a, input int offset_bit);
        return (a >> 2) & ((64'd1 << (offset_bit - 2)) - 64'd1);
    endfunction

endpackage

// File: rtl/icache_stat_cnt.sv
// Saturating 32-bit event counter used for hit/miss statistics (ICACHE_STAT_EN builds).
module icache_stat_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] cnt
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc)
            cnt <= sat_inc(cnt);
    end

endmodule

// File: rtl/icache_ctrl.sv
// Read-only direct-mapped I-cache controller: tag lookup, burst refill, metadata update.
// Optional statistics counters are enabled with the ICACHE_STAT_EN macro.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int BLKIDX_BIT = 4,
    parameter  int OFFSET_BIT = 4,
    localparam int TAG_W      = tag_w(ADDR_W, BLKIDX_BIT, OFFSET_BIT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic [ADDR_W-1:0]     cpu_addr,
    output logic                  cpu_addr_ok,
    output logic                  cpu_data_ok,
    output logic [31:0]           cpu_rdata,
    output logic                  meta_wen,
    output logic [BLKIDX_BIT-1:0] meta_blkidx,
    output logic [TAG_W:0]        meta_wdata,
    input  logic [TAG_W:0]        meta_rdata,
    output logic                  data_wen,
    output logic [BLKIDX_BIT-1:0] data_blkidx,
    output logic [OFFSET_BIT-3:0] data_word,
    output logic [31:0]           data_wdata,
    input  logic [31:0]           data_rdata,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_addr_ok,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rlast
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
`endif
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     req_addr;
    logic [OFFSET_BIT-3:0] cnt;
    logic [TAG_W-1:0]      req_tag;
    logic [BLKIDX_BIT-1:0] req_idx;
    logic [OFFSET_BIT-3:0] req_word;
    logic                  hit;

    assign req_tag  = TAG_W'(addr_tag(64'(req_addr), BLKIDX_BIT, OFFSET_BIT));
    assign req_idx  = BLKIDX_BIT'(addr_idx(64'(req_addr), BLKIDX_BIT, OFFSET_BIT));
    assign req_word = (OFFSET_BIT-2)'(addr_word(64'(req_addr), OFFSET_BIT));
    assign hit      = meta_rdata[TAG_W] && (meta_rdata[TAG_W-1:0] == req_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_addr <= '0;
            cnt      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cpu_req)
                req_addr <= cpu_addr;
            // Beat counter wraps naturally at WORDS; over-long bursts overwrite earlier words.
            if (state_q == MISS && mem_addr_ok)
                cnt <= '0;
            else if (state_q == REFILL && mem_rvalid)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_rdata   = '0;
        meta_wen    = 1'b0;
        meta_blkidx = '0;
        meta_wdata  = '0;
        data_wen    = 1'b0;
        data_blkidx = '0;
        data_word   = '0;
        data_wdata  = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        case (state_q)
            IDLE: begin
                cpu_addr_ok = 1'b1;
                if (cpu_req)
                    state_d = LOOKUP;
            end
            LOOKUP: begin
                meta_blkidx = req_idx;
                data_blkidx = req_idx;
                data_word   = req_word;
                if (hit) begin
                    cpu_data_ok = 1'b1;
                    cpu_rdata   = data_rdata;
                    state_d     = IDLE;
                end else begin
                    state_d = MISS;
                end
            end
            MISS: begin
                mem_req  = 1'b1;
                mem_addr = {req_addr[ADDR_W-1:OFFSET_BIT], {OFFSET_BIT{1'b0}}};
                if (mem_addr_ok)
                    state_d = REFILL;
            end
            REFILL: begin
                if (mem_rvalid) begin
                    data_wen    = 1'b1;
                    data_blkidx = req_idx;
                    data_word   = cnt;
                    data_wdata  = mem_rdata;
                    // Metadata goes valid only on the final beat, so an aborted refill leaves the line invalid.
                    if (mem_rlast) begin
                        meta_wen    = 1'b1;
                        meta_blkidx = req_idx;
                        meta_wdata  = {1'b1, req_tag};
                        state_d     = LOOKUP;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ICACHE_STAT_EN
    logic refilled;

    // Marks the LOOKUP that follows a refill so the guaranteed re-hit is not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            refilled <= 1'b0;
        else if (state_q == REFILL)
            refilled <= 1'b1;
        else if (state_q == IDLE)
            refilled <= 1'b0;
    end

    icache_stat_cnt u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state_q == LOOKUP && hit && !refilled),
        .cnt   (hit_cnt)
    );

    icache_stat_cnt u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state_q == LOOKUP && !hit),
        .cnt   (miss_cnt)
    );
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl with behavioural metadata/data arrays and a bus responder.
module tb_icache_ctrl;

    localparam int ADDR_W     = 32;
    localparam int BLKIDX_BIT = 4;
    localparam int OFFSET_BIT = 4;
    localparam int TAG_W      = 24;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cpu_req;
    logic [ADDR_W-1:0]     cpu_addr;
    logic                  cpu_addr_ok, cpu_data_ok;
    logic [31:0]           cpu_rdata;
    logic                  meta_wen;
    logic [BLKIDX_BIT-1:0] meta_blkidx;
    logic [TAG_W:0]        meta_wdata, meta_rdata;
    logic                  data_wen;
    logic [BLKIDX_BIT-1:0] data_blkidx;
    logic [OFFSET_BIT-3:0] data_word;
    logic [31:0]           data_wdata, data_rdata;
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_addr_ok, mem_rvalid, mem_rlast;
    logic [31:0]           mem_rdata;
`ifdef ICACHE_STAT_EN
    logic [31:0]           hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    icache_ctrl #(.ADDR_W(ADDR_W), .BLKIDX_BIT(BLKIDX_BIT), .OFFSET_BIT(OFFSET_BIT)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_addr_ok(cpu_addr_ok), .cpu_data_ok(cpu_data_ok), .cpu_rdata(cpu_rdata),
        .meta_wen(meta_wen), .meta_blkidx(meta_blkidx), .meta_wdata(meta_wdata),
        .meta_rdata(meta_rdata), .data_wen(data_wen), .data_blkidx(data_blkidx),
        .data_word(data_word), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_addr_ok(mem_addr_ok),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
`ifdef ICACHE_STAT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // Behavioural arrays: combinational read, write on the rising edge.
    logic [TAG_W:0] meta_mem [16];
    logic [31:0]    data_mem [64];

    initial begin
        for (int i = 0; i < 16; i++) meta_mem[i] = '0;
        for (int i = 0; i < 64; i++) data_mem[i] = 32'hDEAD_0000 + 32'(i);
    end

    always @(posedge clk) begin
        if (meta_wen) meta_mem[meta_blkidx] <= meta_wdata;
        if (data_wen) data_mem[{data_blkidx, data_word}] <= data_wdata;
    end

    assign meta_rdata = meta_mem[meta_blkidx];
    assign data_rdata = data_mem[{data_blkidx, data_word}];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          ok_cyc = 0;
    int          last_cyc = 0;
    logic [31:0] sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT returns a word.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && cpu_req && cpu_addr_ok) acc_cyc = cyc;
            if (rst_n === 1'b1 && cpu_data_ok === 1'b1) begin
                ok_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_data_ok: got %0h expected no response", cpu_rdata);
                end else begin
                    exp = sb.pop_front();
                    chk("cpu_rdata", 64'(cpu_rdata), 64'(exp));
                end
            end
        end
    end

    task automatic cpu_fetch(input logic [31:0] a);
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(posedge clk); #1;
        cpu_req  = 1'b0;
    endtask

    task automatic wait_mem_req(output bit seen);
        int n = 0;
        @(negedge clk);
        while (mem_req !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        seen = (mem_req === 1'b1);
        chk("mem_req_seen", 64'(mem_req), 64'(1));
    endtask

    task automatic refill(input logic [31:0] base, input int stall, input logic [31:0] exp_addr,
                          input logic [TAG_W:0] exp_meta, input logic [3:0] exp_idx);
        bit seen;
        wait_mem_req(seen);
        if (!seen) return;
        chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_mem_req", 64'(mem_req), 64'(1));
            chk("stall_mem_addr", 64'(mem_addr), 64'(exp_addr));
            chk("stall_cpu_addr_ok", 64'(cpu_addr_ok), 64'(0));
        end
        mem_addr_ok = 1'b1;
        @(posedge clk); #1;
        mem_addr_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = base + 32'(i);
            mem_rlast  = (i == 3);
            @(negedge clk);
            chk("data_wen", 64'(data_wen), 64'(1));
            chk("data_word", 64'(data_word), 64'(i));
            chk("meta_wen", 64'(meta_wen), 64'(i == 3));
            if (i == 3) begin
                last_cyc = cyc;
                chk("meta_blkidx", 64'(meta_blkidx), 64'(exp_idx));
                chk("meta_wdata", 64'(meta_wdata), 64'(exp_meta));
            end
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        @(negedge clk);
        chk("miss_ret_latency", 64'(ok_cyc - last_cyc), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_addr_ok"}, 64'(cpu_addr_ok), 64'(1));
        chk({tag, "_cpu_data_ok"}, 64'(cpu_data_ok), 64'(0));
        chk({tag, "_mem_req"}, 64'(mem_req), 64'(0));
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
        chk({tag, "_data_wen"}, 64'(data_wen), 64'(0));
        chk({tag, "_meta_wen"}, 64'(meta_wen), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
        mem_addr_ok = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stray beat while idle must not write anything.
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("idle_beat_data_wen", 64'(data_wen), 64'(0));
        @(posedge clk); #1;
        mem_rvalid = 1'b0;

        // Cold miss on 0x1234: index 3, tag 0x12, word 1.
        sb.push_back(32'h0000_00A1);
        cpu_fetch(32'h0000_1234);
        refill(32'h0000_00A0, 0, 32'h0000_1230, {1'b1, 24'h12}, 4'd3);
        chk("meta3_after_fill", 64'(meta_mem[3]), 64'({1'b1, 24'h12}));

        // Hit on the same address.
        sb.push_back(32'h0000_00A1);
        cpu_fetch(32'h0000_1234);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hit_mem_req", 64'(mem_req), 64'(0));
        end
        chk("hit_latency", 64'(ok_cyc - acc_cyc), 64'(1));

        // Conflict miss on the same index with a stalled address handshake.
        sb.push_back(32'h0000_00B1);
        cpu_fetch(32'h0000_2234);
        refill(32'h0000_00B0, 5, 32'h0000_2230, {1'b1, 24'h22}, 4'd3);
        chk("meta3_after_conflict", 64'(meta_mem[3]), 64'({1'b1, 24'h22}));

`ifdef ICACHE_STAT_EN
        @(negedge clk);
        chk("hit_cnt", 64'(hit_cnt), 64'(1));
        chk("miss_cnt", 64'(miss_cnt), 64'(2));
`endif

        // Reset after the second beat of a refill to index 7.
        cpu_fetch(32'h0000_5674);
        wait_mem_req(seen);
        chk("abort_mem_addr", 64'(mem_addr), 64'(32'h0000_5670));
        mem_addr_ok = 1'b1;
        @(posedge clk); #1;
        mem_addr_ok = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_00D0;
        @(posedge clk); #1;
        mem_rdata = 32'h0000_00D1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        mem_rdata = 32'h0000_00D2;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk); #1;
        mem_rdata = 32'h0000_00D3; mem_rlast = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("late_beat_data_wen", 64'(data_wen), 64'(0));
        chk("late_beat_meta_wen", 64'(meta_wen), 64'(0));
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rlast = 1'b0;
        chk("meta7_invalid", 64'(meta_mem[7][TAG_W]), 64'(0));

        // Same line must miss again and refill cleanly.
        sb.push_back(32'h0000_00C1);
        cpu_fetch(32'h0000_5674);
        refill(32'h0000_00C0, 0, 32'h0000_5670, {1'b1, 24'h56}, 4'd7);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Read-only, direct-mapped instruction-cache controller that drives the per-line metadata array (valid bit + tag) and a companion data array. It sits between the CPU fetch stage and the memory bus.
- **Hits:** it reads metadata combinationally, compares the tag and returns the word.
- **Misses:** it issues a line-aligned burst read, writes each returned beat into the data array, then writes `{valid=1, tag}` into the metadata array.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `BLKIDX_BIT`, 4, index bits; `BLK_NUM = 1<<BLKIDX_BIT` lines.
- `OFFSET_BIT`, 4, byte-offset bits; `WORDS = 1<<(OFFSET_BIT-2)` words per line.
- `TAG_W = ADDR_W-BLKIDX_BIT-OFFSET_BIT` (derived, not overridable).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `cpu_req` in 1: fetch request.
- `cpu_addr` in ADDR_W: byte address, word-aligned.
- `cpu_addr_ok` out 1: request accepted this cycle.
- `cpu_data_ok` out 1: `cpu_rdata` valid, one-cycle pulse.
- `cpu_rdata` out 32: fetched word.
- `meta_wen` out 1: metadata write enable.
- `meta_blkidx` out BLKIDX_BIT: metadata index.
- `meta_wdata` out TAG_W+1: `{valid, tag}`.
- `meta_rdata` in TAG_W+1: combinational read of `meta_blkidx`.
- `data_wen` out 1: data-array word write.
- `data_blkidx` out BLKIDX_BIT: data-array line index.
- `data_word` out OFFSET_BIT-2: word within line.
- `data_wdata` out 32: refill word.
- `data_rdata` in 32: combinational read of `{data_blkidx, data_word}`.
- `mem_req` out 1: burst read request.
- `mem_addr` out ADDR_W: line-aligned address, low OFFSET_BIT bits zero.
- `mem_addr_ok` in 1: request accepted.
- `mem_rvalid` in 1: read beat valid.
- `mem_rdata` in 32: beat data.
- `mem_rlast` in 1: final beat.

## Operation
States:
- **IDLE:**
  - `cpu_addr_ok = 1`.
  - On `cpu_req`, latch `cpu_addr` into `req_addr` and go to LOOKUP.
- **LOOKUP:**
  - `meta_blkidx`/`data_blkidx` = `req_addr` index; `data_word = req_addr[OFFSET_BIT-1:2]`.
  - Hit = `meta_rdata[TAG_W]` && `meta_rdata[TAG_W-1:0] == req_addr` tag.
  - On hit: `cpu_data_ok = 1`, `cpu_rdata = data_rdata`, go to IDLE.
  - On miss: go to MISS.
- **MISS:**
  - `mem_req = 1`, `mem_addr = {tag, index, 0}`; hold both until `mem_addr_ok`.
  - Then clear the beat counter and go to REFILL.
- **REFILL:**
  - On each `mem_rvalid`: `data_wen = 1`, `data_word = cnt`, `data_wdata = mem_rdata`, then `cnt++` (wraps mod WORDS).
  - On a beat with `mem_rlast`: also `meta_wen = 1`, `meta_wdata = {1'b1, tag}`, and go to LOOKUP. The re-lookup hits.

Outputs are combinational from state; outputs are 0 outside the listed conditions.

Boundary conditions:
- `mem_rvalid` outside REFILL is ignored.
- `mem_rlast` early (fewer than WORDS beats) still ends the refill; remaining words are stale.
- More than WORDS beats before `mem_rlast`: the counter wraps and overwrites earlier words.
- `cpu_req` outside IDLE is not accepted (`cpu_addr_ok = 0`); the CPU holds it.

## Timing
- Reset values: state IDLE, `req_addr` 0, `cnt` 0.
- Outputs in reset: `cpu_addr_ok = 1`; all other outputs 0.
- Hit latency: accept at cycle N, `cpu_data_ok` at N+1.
- Miss latency: N+1 LOOKUP, then MISS until the `mem_addr_ok` cycle, REFILL until the `mem_rlast` cycle, LOOKUP one cycle later with `cpu_data_ok`.
- `mem_req` and `mem_addr_ok` in the same cycle is a completed handshake; REFILL starts next cycle.
- `meta_wen` and the last `data_wen` occur in the same cycle as `mem_rlast`.
- Asynchronous reset mid-refill:
  - immediate return to IDLE, `mem_req` deasserts;
  - the line's metadata stays unwritten, so the line remains invalid;
  - in-flight beats are ignored.

## Configuration
- `ICACHE_STAT_EN` defined:
  - adds outputs `hit_cnt` and `miss_cnt` (32 bits each), saturating at `32'hFFFF_FFFF` and reset to 0;
  - `hit_cnt` increments on a first LOOKUP hit;
  - `miss_cnt` increments on each LOOKUP miss;
  - the post-refill re-lookup does not count.
- Undefined: the ports and logic are absent; all other behaviour is identical.

## Structure
- Package `icache_pkg`: state enum (IDLE, LOOKUP, MISS, REFILL), tag/index/offset extraction functions, `TAG_W` helper.
- Sub-module `icache_stat_cnt` (saturating counter, instanced twice) exists only under `ICACHE_STAT_EN`.

## Test plan
Parameters are defaults. Address 0x0000_1234 decodes to index 3, tag 0x12, word 1.
- Reset, then request 0x1234 with all metadata invalid:
  - `mem_req` with `mem_addr = 0x1230`;
  - 4 beats 0xA0..0xA3 (`mem_rlast` on the 4th);
  - then `meta_wen` index 3 data `{1, 0x12}`;
  - `cpu_rdata = 0xA1` one cycle later.
- Repeat 0x1234: `cpu_data_ok` exactly 1 cycle after acceptance, data 0xA1, `mem_req` stays 0.
- Request 0x2234 (same index 3, tag 0x22): miss, refill 0xB0..0xB3, returns 0xB1; metadata index 3 becomes `{1, 0x22}`.
- `mem_addr_ok` held low for 5 cycles: `mem_req` and `mem_addr` stable throughout; `cpu_addr_ok` stays 0.
- Drop `rst_n` after the 2nd refill beat:
  - all outputs are at reset values immediately;
  - later beats are ignored;
  - next request to the same line misses again.
- With `ICACHE_STAT_EN`, run the sequence miss, hit, miss: `hit_cnt = 1`, `miss_cnt = 2`.
